// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between the fetch port and the data port, with data priority and a bounded fetch-starvation guard.
// Define MEM_ARB_PERF_EN to add the perf_conflicts / perf_starve_grants counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_ack,
    output logic              inst_stall,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_ack,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_starve_grants,
`endif
    input  logic              bus_ack
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t            r_state, w_state_nxt;
    logic              r_bus_req, w_req_nxt, r_bus_we, w_we_nxt;
    logic [ADDR_W-1:0] r_bus_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_bus_wdata, w_wdata_nxt, r_inst_data, w_idata_nxt, r_mem_din, w_ddata_nxt;
    logic              r_inst_ack, w_iack_nxt, r_mem_ack, w_mack_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_mem_req, w_guard, w_sel_d, w_sel_i;
    assign w_mem_req  = mem_ren | mem_wen;
    assign w_guard    = inst_ren && (r_cnt == CNT_W'(STARVE_LIMIT));
    assign w_sel_d    = (r_state == IDLE) && w_mem_req && !w_guard;
    assign w_sel_i    = (r_state == IDLE) && inst_ren && !w_sel_d;
    assign w_cnt_nxt  = (!inst_ren || w_sel_i) ? '0 : (w_sel_d && r_cnt != CNT_W'(STARVE_LIMIT)) ? r_cnt + 1'b1 : r_cnt;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign inst_data  = r_inst_data;
    assign inst_ack   = r_inst_ack;
    assign mem_din    = r_mem_din;
    assign mem_ack    = r_mem_ack;
    assign inst_stall = rst & inst_ren & ~r_inst_ack;
    assign mem_stall  = rst & w_mem_req & ~r_mem_ack;
    // Next-state and next-output decode: grant from IDLE, hold bus signals until bus_ack, then return the result
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_bus_req;
        w_we_nxt    = r_bus_we;
        w_addr_nxt  = r_bus_addr;
        w_wdata_nxt = r_bus_wdata;
        w_idata_nxt = r_inst_data;
        w_ddata_nxt = r_mem_din;
        w_iack_nxt  = 1'b0;
        w_mack_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_d) begin
                    w_state_nxt = BUSY_D;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = mem_wen;
                    w_addr_nxt  = mem_addr;
                    w_wdata_nxt = mem_dout;
                end else if (w_sel_i) begin
                    w_state_nxt = BUSY_I;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = inst_addr;
                end
            end
            BUSY_D: begin
                if (bus_ack) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_mack_nxt  = 1'b1;
                    w_ddata_nxt = r_bus_we ? r_mem_din : bus_rdata;
                end
            end
            BUSY_I: begin
                if (bus_ack) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_iack_nxt  = 1'b1;
                    w_idata_nxt = bus_rdata;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    // State and registered bus/port outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_inst_data <= '0;
            r_mem_din   <= '0;
            r_inst_ack  <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_req   <= w_req_nxt;
            r_bus_we    <= w_we_nxt;
            r_bus_addr  <= w_addr_nxt;
            r_bus_wdata <= w_wdata_nxt;
            r_inst_data <= w_idata_nxt;
            r_mem_din   <= w_ddata_nxt;
            r_inst_ack  <= w_iack_nxt;
            r_mem_ack   <= w_mack_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end
`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_conf, r_perf_starve;
    assign perf_conflicts     = r_perf_conf;
    assign perf_starve_grants = r_perf_starve;
    // Count IDLE cycles with both ports requesting, and fetch grants won only because of the guard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_conf   <= '0;
            r_perf_starve <= '0;
        end else begin
            r_perf_conf   <= r_perf_conf + 32'((r_state == IDLE) && inst_ren && w_mem_req);
            r_perf_starve <= r_perf_starve + 32'(w_sel_i && w_mem_req);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written multi-cycle sequences for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_ren = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0, force_ack = 1'b0;
    logic [31:0] inst_addr = '0, mem_addr = '0, mem_dout = '0, rdata = '0;
    logic [31:0] inst_data, mem_din, bus_addr, bus_wdata;
    logic        inst_ack, inst_stall, mem_ack, mem_stall, bus_req, bus_we, bus_ack;
    logic [3:0]  r_wait;
    int          lat = 0;
    int          n_cmp = 0, n_bad = 0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_starve_grants;
`endif

    typedef struct {
        logic        ir, mr, mw;
        logic [31:0] ia, ma, md, rd;
        logic        port;
        logic        we;
        logic [31:0] addr, dout;
    } vec_t;
    vec_t vt [5];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
        .inst_ack(inst_ack), .inst_stall(inst_stall),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_conflicts(perf_conflicts), .perf_starve_grants(perf_starve_grants),
`endif
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) r_wait <= 4'd0;
        else      r_wait <= (bus_req && !bus_ack) ? r_wait + 4'd1 : 4'd0;
    assign bus_ack = force_ack | (bus_req && (int'(r_wait) == lat));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        inst_ren = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g [6];
        logic [5:0]  exp_g;
        logic        prev;
        int          ng;
        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h11111111, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h14, 32'h22222222, 32'h0BADF00D, 1'b1, 1'b1, 32'h14, 32'hA5A5A5A5};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h18, 32'h33333333, 32'h0BADF00D, 1'b1, 1'b1, 32'h18, 32'hA5A5A5A5};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 32'h20080001, 1'b0, 1'b0, 32'h104, 32'h20080001};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h1C, 32'h44444444, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h1C, 32'h5A5A5A5A};

        inst_ren = 1'b1;
        mem_ren  = 1'b1;
        repeat (2) tick;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_acks", {inst_ack, mem_ack}, 0);
        chk("rst_stalls", {inst_stall, mem_stall}, 0);
        clr();
        rst = 1'b1;
        tick;

        lat = 1;
        rdata = 32'h8C010004;
        inst_addr = 32'h100;
        inst_ren = 1'b1;
        #1 chk("fetch_c0_stall", inst_stall, 1);
        tick;
        chk("fetch_c1_req", {bus_req, bus_we}, 2'b10);
        chk("fetch_c1_addr", bus_addr, 32'h100);
        chk("fetch_c1_stall_ack", {inst_stall, inst_ack}, 2'b10);
        tick;
        chk("fetch_c2_req_stall", {bus_req, inst_stall, inst_ack}, 3'b110);
        tick;
        chk("fetch_c3_ack_stall", {inst_ack, inst_stall, bus_req}, 3'b100);
        chk("fetch_c3_data", inst_data, 32'h8C010004);
        clr();
        tick;
        chk("fetch_c4_ack_low", inst_ack, 0);
        chk("fetch_c4_data_held", inst_data, 32'h8C010004);

        lat = 0;
        rdata = 32'h0C000000;
        inst_addr = 32'h200;
        inst_ren = 1'b1;
        mem_addr = 32'h40;
        mem_dout = 32'hDEADBEEF;
        mem_wen = 1'b1;
        tick;
        chk("simul_c1_we", {bus_req, bus_we}, 2'b11);
        chk("simul_c1_addr", bus_addr, 32'h40);
        chk("simul_c1_wdata", bus_wdata, 32'hDEADBEEF);
        tick;
        chk("simul_c2_mack", {mem_ack, mem_stall, inst_stall, bus_req}, 4'b1010);
        chk("simul_c2_din_unchanged", mem_din, 0);
        mem_wen = 1'b0;
        tick;
        chk("simul_c3_fetch", {bus_req, bus_we, mem_ack}, 3'b100);
        chk("simul_c3_addr", bus_addr, 32'h200);
        tick;
        chk("simul_c4_iack", inst_ack, 1);
        chk("simul_c4_data", inst_data, 32'h0C000000);
        clr();
        tick;

        for (int i = 0; i < 5; i++) begin
            inst_ren = vt[i].ir;
            mem_ren = vt[i].mr;
            mem_wen = vt[i].mw;
            inst_addr = vt[i].ia;
            mem_addr = vt[i].ma;
            mem_dout = vt[i].md;
            rdata = vt[i].rd;
            #1;
            chk($sformatf("vec%0d_stalls", i), {inst_stall, mem_stall}, {vt[i].ir, vt[i].mr | vt[i].mw});
            tick;
            chk($sformatf("vec%0d_req_we", i), {bus_req, bus_we}, {1'b1, vt[i].we});
            chk($sformatf("vec%0d_addr", i), bus_addr, vt[i].addr);
            if (vt[i].port) chk($sformatf("vec%0d_wdata", i), bus_wdata, vt[i].md);
            tick;
            chk($sformatf("vec%0d_acks", i), {inst_ack, mem_ack}, {~vt[i].port, vt[i].port});
            chk($sformatf("vec%0d_dout", i), vt[i].port ? mem_din : inst_data, vt[i].dout);
            clr();
            tick;
        end

        lat = 5;
        rdata = 32'h12345678;
        mem_addr = 32'h1C0;
        mem_ren = 1'b1;
        tick;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("slow_c%0d_req_stall_ack", c), {bus_req, mem_stall, mem_ack, bus_we}, 4'b1100);
            chk($sformatf("slow_c%0d_addr", c), bus_addr, 32'h1C0);
            tick;
        end
        chk("slow_ack", {mem_ack, mem_stall}, 2'b10);
        chk("slow_din", mem_din, 32'h12345678);
        clr();
        tick;

        force_ack = 1'b1;
        rdata = 32'hFFFFFFFF;
        repeat (2) begin
            tick;
            chk("idle_ack_ignored", {bus_req, inst_ack, mem_ack}, 0);
            chk("idle_ack_din", mem_din, 32'h12345678);
            chk("idle_ack_idata", inst_data, 32'h20080001);
        end
        force_ack = 1'b0;

        lat = 0;
        rdata = 32'h0;
        inst_addr = 32'h300;
        mem_addr = 32'h80;
        inst_ren = 1'b1;
        mem_ren = 1'b1;
        exp_g = 6'b010000;
        ng = 0;
        prev = bus_req;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            tick;
            if (bus_req && !prev) begin
                g[ng] = (bus_addr == 32'h300);
                ng++;
            end
            prev = bus_req;
            if (inst_ack) inst_ren = 1'b0;
        end
        clr();
        chk("starve_grant_count", ng, 6);
        for (int k = 0; k < 6; k++)
            if (k < ng) chk($sformatf("starve_grant%0d_is_fetch", k), g[k], exp_g[k]);
        repeat (3) tick;
`ifdef MEM_ARB_PERF_EN
        chk("perf_starve_grants", perf_starve_grants, 1);
`endif

        lat = 10;
        mem_addr = 32'h24;
        mem_ren = 1'b1;
        tick;
        chk("rmid_c1_req", bus_req, 1);
        tick;
        rst = 1'b0;
        #1;
        chk("rmid_req_drop", bus_req, 0);
        chk("rmid_stall", mem_stall, 0);
        chk("rmid_addr_din", {bus_addr, mem_din}, 0);
        clr();
        repeat (2) begin
            tick;
            chk("rmid_no_ack", {mem_ack, bus_req}, 0);
        end
        rst = 1'b1;
        lat = 0;
        rdata = 32'hCAFE0001;
        mem_addr = 32'h28;
        mem_ren = 1'b1;
        tick;
        chk("rmid_fresh_req", {bus_req, bus_we}, 2'b10);
        chk("rmid_fresh_addr", bus_addr, 32'h28);
        tick;
        chk("rmid_fresh_ack", mem_ack, 1);
        chk("rmid_fresh_din", mem_din, 32'hCAFE0001);
        clr();
        tick;

`ifdef MEM_ARB_PERF_EN
        chk("perf_after_reset", {perf_conflicts[15:0], perf_starve_grants[15:0]}, 0);
        inst_addr = 32'h400;
        mem_addr = 32'h90;
        inst_ren = 1'b1;
        mem_ren = 1'b1;
        repeat (5) tick;
        clr();
        repeat (2) tick;
        chk("perf_conflicts", perf_conflicts, 3);
        chk("perf_no_starve", perf_starve_grants, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
